// File: rtl/dac_play_sched.sv
// Playback scheduler: pulls words from the UDP word FIFO and paces four byte
// strobes per word into the serializer. Optional mid-scale fill: DAC_ZERO_FILL_EN.
module dac_play_sched #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             play_start,
  input  logic             play_stop,
  input  logic [DIV_W-1:0] rate_div,
  input  logic             fifo_empty,
  input  logic [31:0]      fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             conv_en,
  output logic [31:0]      conv_data,
  output logic             busy,
  output logic             underrun,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] underrun_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_q, tick_cnt;
  logic [1:0]       byte_idx;
  logic             stop_pending, tick, start_ok;
  logic             load_word, fill, hold_load;

`ifdef DAC_ZERO_FILL_EN
  logic [31:0] hold_data;
  logic        hold_vld;
`endif

  assign busy     = (state != IDLE);
  assign tick     = busy && (tick_cnt == div_q);
  assign start_ok = (state == IDLE) && play_start && !play_stop;

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    conv_en    = 1'b0;
    underrun   = 1'b0;
    load_word  = 1'b0;
    fill       = 1'b0;
    hold_load  = 1'b0;
    unique case (state)
      IDLE: if (start_ok) state_nxt = FETCH;
      FETCH: begin
        underrun = tick;
        if (stop_pending) state_nxt = IDLE;
`ifdef DAC_ZERO_FILL_EN
        // A tick here means no word is ready; no read is issued once fill starts.
        else if (tick) begin
          fill      = 1'b1;
          conv_en   = 1'b1;
          state_nxt = PLAY;
        end
`endif
        else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        underrun  = tick;
        state_nxt = PLAY;
`ifdef DAC_ZERO_FILL_EN
        if (tick) begin
          fill    = 1'b1;
          conv_en = 1'b1;
        end else begin
          load_word = 1'b1;
        end
`else
        load_word = 1'b1;
`endif
      end
      PLAY: if (tick) begin
        conv_en = 1'b1;
        if (byte_idx == 2'd3) begin
          state_nxt = stop_pending ? IDLE : FETCH;
`ifdef DAC_ZERO_FILL_EN
          // A word read before the fill began plays right after it.
          if (hold_vld) begin
            hold_load = 1'b1;
            state_nxt = PLAY;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_q        <= '0;
      tick_cnt     <= '0;
      stop_pending <= 1'b0;
      byte_cnt     <= '0;
      underrun_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        div_q        <= (rate_div < DIV_W'(2)) ? DIV_W'(2) : rate_div;
        tick_cnt     <= '0;
        stop_pending <= 1'b0;
        byte_cnt     <= '0;
        underrun_cnt <= '0;
      end else begin
        if (busy) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (busy && play_stop) stop_pending <= 1'b1;
        if (conv_en && (byte_cnt != '1)) byte_cnt <= byte_cnt + 1'b1;
        if (underrun && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_data <= '0;
      byte_idx  <= '0;
    end else if (load_word) begin
      conv_data <= fifo_rd_data;
      byte_idx  <= '0;
    end else if (fill) begin
      conv_data <= 32'h8080_8080;
      byte_idx  <= 2'd1;
`ifdef DAC_ZERO_FILL_EN
    end else if (hold_load) begin
      conv_data <= hold_data;
      byte_idx  <= '0;
`endif
    end else if (conv_en) begin
      byte_idx <= byte_idx + 1'b1;
    end
  end

`ifdef DAC_ZERO_FILL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_vld  <= 1'b0;
    end else if (start_ok || hold_load) begin
      hold_vld <= 1'b0;
    end else if (fill && (state == LOAD)) begin
      hold_data <= fifo_rd_data;
      hold_vld  <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_play_sched.sv
// Bench for dac_play_sched: a word FIFO model, a tick-arithmetic reference of the
// playback rules, and directed plus random stimulus.
module tb_dac_play_sched;
  localparam int DIV_W = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             play_start = 1'b0, play_stop = 1'b0;
  logic [DIV_W-1:0] rate_div = '0;
  logic             fifo_empty = 1'b1;
  logic [31:0]      fifo_rd_data = '0;
  logic             fifo_rd_en, conv_en, busy, underrun;
  logic [31:0]      conv_data;
  logic [CNT_W-1:0] byte_cnt, underrun_cnt;

  dac_play_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .play_start(play_start), .play_stop(play_stop),
    .rate_div(rate_div), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .conv_en(conv_en), .conv_data(conv_data), .busy(busy),
    .underrun(underrun), .byte_cnt(byte_cnt), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] fq[$], mq[$];
  logic [31:0] rdata_nxt = '0;
  bit          rdata_vld = 0;

  bit               st_req = 0, sp_req = 0, push_req = 0;
  logic [31:0]      push_val = '0;
  logic [DIV_W-1:0] rd_req = '0;

  // reference: period arithmetic from the start cycle, bytes left in the held word
  bit          m_active = 0, m_pend = 0, m_stopping = 0;
  int          m_since = 0, m_P = 3, m_left = 0, m_bytes = 0, m_ur = 0;
  logic [31:0] m_data = '0, m_pend_data = '0;

  int          rd_seen = 0, ur_seen = 0;
  int          strobe_t[$];
  logic [31:0] strobe_d[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_pend = 0; m_stopping = 0; m_left = 0;
    m_bytes = 0; m_ur = 0; m_data = '0;
  endtask

  task automatic step();
    bit m_tick, e_rd, e_en, e_ur;
    @(negedge clk);
    cyc++;
    if (push_req) begin fq.push_back(push_val); mq.push_back(push_val); end
    if (rdata_vld) begin fifo_rd_data = rdata_nxt; rdata_vld = 0; end
    play_start = st_req; play_stop = sp_req; rate_div = rd_req;
    fifo_empty = (fq.size() == 0);
    #1;
    m_tick = m_active && (m_since > 0) && ((m_since % m_P) == 0);
    e_rd   = m_active && (m_left == 0) && !m_pend && !m_stopping && !fifo_empty;
    e_en   = m_tick && (m_left > 0);
    e_ur   = m_tick && (m_left == 0);
    chk("busy", busy, m_active);
    chk("fifo_rd_en", fifo_rd_en, e_rd);
    chk("conv_en", conv_en, e_en);
    chk("underrun", underrun, e_ur);
    chk("conv_data", conv_data, m_data);
    chk("byte_cnt", byte_cnt, m_bytes);
    chk("underrun_cnt", underrun_cnt, m_ur);
    if (fifo_rd_en) rd_seen++;
    if (underrun) ur_seen++;
    if (conv_en) begin strobe_t.push_back(cyc); strobe_d.push_back(conv_data); end
    if (!m_active) begin
      if (play_start && !play_stop) begin
        m_active = 1; m_since = 1; m_left = 0; m_pend = 0; m_stopping = 0;
        m_P = ((rate_div < 2) ? 2 : int'(rate_div)) + 1;
        m_bytes = 0; m_ur = 0;
      end
    end else begin
      if (e_en) begin
        m_bytes++; m_left--;
        if (m_left == 0 && m_stopping) m_active = 0;
      end else if (m_pend) begin
        m_data = m_pend_data; m_left = 4; m_pend = 0;
      end else if (m_left == 0) begin
        if (m_stopping) m_active = 0;
        else if (!fifo_empty) begin
          m_pend = 1;
          m_pend_data = (mq.size() > 0) ? mq.pop_front() : 32'hBAD0_BAD0;
        end
      end
      if (e_ur) m_ur++;
      if (play_stop) m_stopping = 1;
      m_since++;
    end
    if (fifo_rd_en && fq.size() > 0) begin rdata_nxt = fq.pop_front(); rdata_vld = 1; end
    st_req = 0; sp_req = 0; push_req = 0;
  endtask

  task automatic push(input logic [31:0] v);
    push_req = 1; push_val = v; step();
  endtask

  task automatic start();
    st_req = 1; step();
  endtask

  task automatic stop_and_idle(input string nm);
    int n;
    sp_req = 1; step();
    n = 0;
    while (m_active && n < 200) begin step(); n++; end
    chk({nm, "_stop_timeout"}, n < 200, 1);
    repeat (3) step();
  endtask

  task automatic check_zero_outputs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_conv_en"}, conv_en, 0);
    chk({nm, "_rd_en"}, fifo_rd_en, 0);
    chk({nm, "_underrun"}, underrun, 0);
    chk({nm, "_conv_data"}, conv_data, 0);
    chk({nm, "_byte_cnt"}, byte_cnt, 0);
    chk({nm, "_underrun_cnt"}, underrun_cnt, 0);
  endtask

  initial begin
    int n, bad;
    rd_req = 3;
    #3;
    check_zero_outputs("reset");
    step(); step();
    rst_n = 1;

    // two words at rate_div=3: 8 strobes 4 cycles apart, then underruns
    push(32'h1122_3344); push(32'h5566_7788);
    strobe_t.delete(); strobe_d.delete(); rd_seen = 0; ur_seen = 0;
    start();
    repeat (40) step();
    chk("t1_strobes", strobe_t.size(), 8);
    bad = 0;
    for (int i = 1; i < strobe_t.size(); i++) if (strobe_t[i] - strobe_t[i-1] != 4) bad++;
    chk("t1_spacing", bad, 0);
    bad = 0;
    for (int i = 0; i < strobe_d.size(); i++)
      if (strobe_d[i] != ((i < 4) ? 32'h1122_3344 : 32'h5566_7788)) bad++;
    chk("t1_data", bad, 0);
    chk("t1_byte_cnt", byte_cnt, 8);
    chk("t1_reads", rd_seen, 2);
    chk("t1_underruns", ur_seen, 2);
    stop_and_idle("t1");

    // rate_div=0 clamps to 2: strobes 3 apart with no underrun while data lasts
    rd_req = 0;
    for (int i = 0; i < 6; i++) push($urandom);
    strobe_t.delete(); ur_seen = 0;
    start();
    n = 0;
    while (m_bytes < 24 && n < 400) begin step(); n++; end
    chk("t2_timeout", n < 400, 1);
    bad = 0;
    for (int i = 1; i < strobe_t.size(); i++) if (strobe_t[i] - strobe_t[i-1] != 3) bad++;
    chk("t2_spacing", bad, 0);
    chk("t2_strobes", strobe_t.size(), 24);
    chk("t2_underruns", ur_seen, 0);
    stop_and_idle("t2");

    // stop after 2nd strobe: the word completes, no further reads
    rd_req = 2;
    push(32'hCAFE_0001); push(32'hCAFE_0002); push(32'hCAFE_0003);
    rd_seen = 0;
    start();
    n = 0;
    while (m_bytes < 2 && n < 100) begin step(); n++; end
    chk("t3_timeout", n < 100, 1);
    sp_req = 1; step();
    repeat (20) step();
    chk("t3_busy", busy, 0);
    chk("t3_byte_cnt", byte_cnt, 4);
    chk("t3_reads", rd_seen, 1);
    fq.delete(); mq.delete();

    // empty FIFO for 10 ticks, then one word
    rd_req = 3;
    start();
    n = 0;
    while (m_ur < 10 && n < 100) begin step(); n++; end
    chk("t4_timeout", n < 100, 1);
    push(32'hA0B0_C0D0);
    n = 0;
    while (m_bytes < 4 && n < 100) begin step(); n++; end
    chk("t4_timeout2", n < 100, 1);
    @(posedge clk); #1;
    chk("t4_underrun_cnt", underrun_cnt, 10);
    chk("t4_byte_cnt", byte_cnt, 4);
    chk("t4_conv_data", conv_data, 32'hA0B0_C0D0);
    stop_and_idle("t4");

    // asynchronous reset in the middle of a word, then clean restart
    rd_req = 2;
    push(32'h0102_0304); push(32'h0506_0708);
    start();
    n = 0;
    while (m_bytes < 2 && n < 100) begin step(); n++; end
    chk("t5_timeout", n < 100, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check_zero_outputs("t5_async");
    model_reset(); fq.delete(); mq.delete(); rdata_vld = 0;
    step(); step();
    rst_n = 1;
    push(32'hDEAD_BEEF);
    start();
    n = 0;
    while (m_bytes < 1 && n < 100) begin step(); n++; end
    chk("t5_timeout2", n < 100, 1);
    @(posedge clk); #1;
    chk("t5_conv_data", conv_data, 32'hDEAD_BEEF);
    chk("t5_byte_cnt", byte_cnt, 1);
    stop_and_idle("t5");

    // random starts, stops, pushes and rate changes
    for (int i = 0; i < 2500; i++) begin
      rd_req   = DIV_W'($urandom_range(0, 5));
      st_req   = ($urandom_range(0, 29) == 0);
      sp_req   = ($urandom_range(0, 59) == 0);
      push_req = (fq.size() < 6) && ($urandom_range(0, 2) == 0);
      push_val = $urandom;
      step();
    end
    stop_and_idle("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
